// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin scheduler for the shared writeback/CDB port, one holding buffer per FU.
// Optional macro CDB_PERF_CNT_EN adds perf_grants / perf_conflicts counter outputs.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module cdb_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned FU_IDW = $clog2(NUM_FU),
    parameter int unsigned XLEN   = 32
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  squash,
    input  logic [NUM_FU-1:0]                     fu_valid,
    input  logic [NUM_FU-1:0][4:0]                fu_rd,
    input  logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0]   fu_rob_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]           fu_value,
    output logic [NUM_FU-1:0]                     fu_ready,
    output logic                                  cdb_valid,
    output logic [4:0]                            cdb_rd,
    output logic [`ROB_TAG_LEN-1:0]               cdb_rob_tag,
    output logic [XLEN-1:0]                       cdb_value,
    output logic [FU_IDW-1:0]                     cdb_fu_id
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0]                           perf_grants,
    output logic [31:0]                           perf_conflicts
`endif
);

    localparam int unsigned RDW  = 5;
    localparam int unsigned TAGW = `ROB_TAG_LEN;
    localparam int unsigned CNTW = FU_IDW + 1;

    typedef struct packed {
        logic [RDW-1:0]  rd;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] value;
    } wb_t;

    wb_t                buf_q [NUM_FU];
    logic [NUM_FU-1:0]  buf_valid;
    logic [FU_IDW-1:0]  rr_ptr;

    logic [NUM_FU-1:0]  grant;
    logic [NUM_FU-1:0]  accept;
    logic               grant_any;
    logic [FU_IDW-1:0]  grant_id;
    logic [FU_IDW-1:0]  next_ptr;
    logic [CNTW-1:0]    scan_idx;

    // Round-robin pick: first buffered FU at or after rr_ptr, wrapping at NUM_FU.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            scan_idx = CNTW'(rr_ptr) + CNTW'(k);
            if (scan_idx >= CNTW'(NUM_FU)) begin
                scan_idx = scan_idx - CNTW'(NUM_FU);
            end
            if (!grant_any && buf_valid[scan_idx[FU_IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx[FU_IDW-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign next_ptr = (grant_id == FU_IDW'(NUM_FU - 1)) ? '0 : grant_id + FU_IDW'(1);

    // A buffer being drained this cycle can be refilled at the same edge.
    assign fu_ready = squash ? '0 : (~buf_valid | grant);
    assign accept   = fu_valid & fu_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid   <= '0;
            rr_ptr      <= '0;
            cdb_valid   <= 1'b0;
            cdb_rd      <= '0;
            cdb_rob_tag <= '0;
            cdb_value   <= '0;
            cdb_fu_id   <= '0;
        end else if (squash) begin
            buf_valid <= '0;
            cdb_valid <= 1'b0;
        end else begin
            buf_valid <= (buf_valid & ~grant) | accept;
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_rd      <= buf_q[grant_id].rd;
                cdb_rob_tag <= buf_q[grant_id].tag;
                cdb_value   <= buf_q[grant_id].value;
                cdb_fu_id   <= grant_id;
                rr_ptr      <= next_ptr;
            end
        end
    end

    // Payload storage needs no reset; buf_valid qualifies it.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                buf_q[i] <= '{rd: fu_rd[i], tag: fu_rob_tag[i], value: fu_value[i]};
            end
        end
    end

`ifdef CDB_PERF_CNT_EN
    logic multi_valid;

    assign multi_valid = |(buf_valid & (buf_valid - NUM_FU'(1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grants    <= '0;
            perf_conflicts <= '0;
        end else begin
            if (grant_any && !squash) begin
                perf_grants <= perf_grants + 32'd1;
            end
            if (multi_valid) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic checked against a result-buffer model.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = `ROB_TAG_LEN;
    localparam int XL = 32;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     squash;
    logic [N-1:0]             fu_valid;
    logic [N-1:0][4:0]        fu_rd;
    logic [N-1:0][TW-1:0]     fu_rob_tag;
    logic [N-1:0][XL-1:0]     fu_value;
    logic [N-1:0]             fu_ready;
    logic                     cdb_valid;
    logic [4:0]               cdb_rd;
    logic [TW-1:0]            cdb_rob_tag;
    logic [XL-1:0]            cdb_value;
    logic [1:0]               cdb_fu_id;
`ifdef CDB_PERF_CNT_EN
    logic [31:0]              perf_grants;
    logic [31:0]              perf_conflicts;
`endif

    cdb_arbiter #(.NUM_FU(N), .XLEN(XL)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .fu_valid    (fu_valid),
        .fu_rd       (fu_rd),
        .fu_rob_tag  (fu_rob_tag),
        .fu_value    (fu_value),
        .fu_ready    (fu_ready),
        .cdb_valid   (cdb_valid),
        .cdb_rd      (cdb_rd),
        .cdb_rob_tag (cdb_rob_tag),
        .cdb_value   (cdb_value),
        .cdb_fu_id   (cdb_fu_id)
`ifdef CDB_PERF_CNT_EN
        ,
        .perf_grants    (perf_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: pending result per FU, round-robin start point, last broadcast.
    bit            m_bv  [N];
    logic [4:0]    m_rd  [N];
    logic [TW-1:0] m_tag [N];
    logic [XL-1:0] m_val [N];
    int            m_ptr;
    bit            e_valid;
    logic [4:0]    e_rd;
    logic [TW-1:0] e_tag;
    logic [XL-1:0] e_val;
    int            e_id;
    longint        m_grants;
    longint        m_conf;

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (m_bv[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready(input logic sq);
        int w = m_winner();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = !sq && (!m_bv[i] || w == i);
        return r;
    endfunction

    // Advance the model over the coming edge using the currently driven inputs, then cross it.
    task automatic cycle();
        int w = m_winner();
        logic [N-1:0] rdy = m_ready(squash);
        int pending = 0;
        for (int i = 0; i < N; i++) pending += int'(m_bv[i]);
        if (pending >= 2) m_conf++;
        if (reset) begin
            for (int i = 0; i < N; i++) m_bv[i] = 0;
            m_ptr = 0; e_valid = 0; e_rd = '0; e_tag = '0; e_val = '0; e_id = 0;
            m_grants = 0; m_conf = 0;
        end else if (squash) begin
            for (int i = 0; i < N; i++) m_bv[i] = 0;
            e_valid = 0;
        end else begin
            if (w >= 0) begin
                e_valid = 1; e_rd = m_rd[w]; e_tag = m_tag[w]; e_val = m_val[w]; e_id = w;
                m_ptr = (w + 1) % N; m_bv[w] = 0; m_grants++;
            end else begin
                e_valid = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (fu_valid[i] && rdy[i]) begin
                    m_bv[i] = 1; m_rd[i] = fu_rd[i]; m_tag[i] = fu_rob_tag[i]; m_val[i] = fu_value[i];
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; squash = 1'b0; fu_valid = '0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        fu_rd = '0; fu_rob_tag = '0; fu_value = '0;
        do_reset();
        do_reset();
        #1;
        tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
        tests++; if (fu_ready !== 4'b1111) begin fails++; $display("FAIL reset_ready got=%b exp=1111", fu_ready); end
        tests++;
        if (cdb_rd !== 5'd0 || cdb_rob_tag !== '0 || cdb_value !== 32'd0 || cdb_fu_id !== 2'd0) begin
            fails++; $display("FAIL reset_fields got rd=%0d tag=%0d val=%h id=%0d exp all 0", cdb_rd, cdb_rob_tag, cdb_value, cdb_fu_id);
        end
    endtask

    task automatic test_single_latency();
        fu_valid = 4'b0100; fu_rd[2] = 5'd5; fu_rob_tag[2] = TW'(3); fu_value[2] = 32'hDEAD;
        cycle();
        fu_valid = '0;
        tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL lat_n1 got=%b exp=0", cdb_valid); end
        cycle();
        tests++;
        if (cdb_valid !== 1'b1 || cdb_rd !== 5'd5 || cdb_rob_tag !== TW'(3) || cdb_value !== 32'hDEAD || cdb_fu_id !== 2'd2) begin
            fails++; $display("FAIL lat_n2 got v=%b rd=%0d tag=%0d val=%h id=%0d exp v=1 rd=5 tag=3 val=dead id=2",
                              cdb_valid, cdb_rd, cdb_rob_tag, cdb_value, cdb_fu_id);
        end
        cycle();
        tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL lat_pulse got=%b exp=0", cdb_valid); end
    endtask

    task automatic test_all_requesting();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            fu_valid = 4'b1111;
            for (int i = 0; i < N; i++) begin
                fu_value[i] = {28'(c), 4'(i)}; fu_rd[i] = 5'(i + 1); fu_rob_tag[i] = TW'(i);
            end
            cycle();
            if (c >= 1) begin
                tests++;
                if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'((c - 1) % N) || cdb_value[3:0] !== 4'((c - 1) % N)) begin
                    fails++; $display("FAIL rr_order c=%0d got v=%b id=%0d exp v=1 id=%0d", c, cdb_valid, cdb_fu_id, (c - 1) % N);
                end
            end
        end
        fu_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            fu_valid = (c < 8) ? 4'b0010 : 4'b0000;
            fu_value[1] = 32'(c + 1); fu_rd[1] = 5'd7; fu_rob_tag[1] = TW'(c);
            #1;
            if (c < 8) begin
                tests++; if (fu_ready[1] !== 1'b1) begin fails++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, fu_ready[1]); end
            end
            cycle();
            tests++;
            if (c >= 1 && c <= 8) begin
                if (cdb_valid !== 1'b1 || cdb_value !== 32'(c) || cdb_fu_id !== 2'd1) begin
                    fails++; $display("FAIL b2b_bcast c=%0d got v=%b val=%0d id=%0d exp v=1 val=%0d id=1", c, cdb_valid, cdb_value, cdb_fu_id, c);
                end
            end else if (cdb_valid !== 1'b0) begin
                fails++; $display("FAIL b2b_idle c=%0d got v=%b exp=0", c, cdb_valid);
            end
        end
`ifdef CDB_PERF_CNT_EN
        tests++;
        if (perf_grants !== 32'd8 || perf_conflicts !== 32'd0) begin
            fails++; $display("FAIL b2b_perf got g=%0d c=%0d exp g=8 c=0", perf_grants, perf_conflicts);
        end
`endif
    endtask

    task automatic test_squash();
        do_reset();
        fu_valid = 4'b1001; fu_value[0] = 32'hAAAA; fu_value[3] = 32'hBBBB;
        cycle();
        fu_valid = '0; squash = 1'b1;
        #1;
        tests++; if (fu_ready !== 4'b0000) begin fails++; $display("FAIL sq_ready_during got=%b exp=0000", fu_ready); end
        cycle();
        squash = 1'b0;
        #1;
        tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL sq_valid got=%b exp=0", cdb_valid); end
        tests++; if (fu_ready !== 4'b1111) begin fails++; $display("FAIL sq_ready_after got=%b exp=1111", fu_ready); end
        for (int c = 0; c < 3; c++) begin
            cycle();
            tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL sq_nobcast c=%0d got=%b exp=0", c, cdb_valid); end
        end
    endtask

    task automatic test_reset_dominates();
        fu_valid = 4'b0111; fu_value = '1;
        cycle();
        reset = 1'b1; squash = 1'b1; fu_valid = 4'b1111;
        cycle();
        reset = 1'b0; squash = 1'b0; fu_valid = '0;
        #1;
        tests++;
        if (cdb_valid !== 1'b0 || fu_ready !== 4'b1111 || cdb_rd !== 5'd0 || cdb_rob_tag !== '0 || cdb_value !== 32'd0 || cdb_fu_id !== 2'd0) begin
            fails++; $display("FAIL rst_dom got v=%b rdy=%b rd=%0d val=%h id=%0d exp v=0 rdy=1111 fields 0",
                              cdb_valid, fu_ready, cdb_rd, cdb_value, cdb_fu_id);
        end
`ifdef CDB_PERF_CNT_EN
        tests++;
        if (perf_grants !== 32'd0 || perf_conflicts !== 32'd0) begin
            fails++; $display("FAIL rst_perf got g=%0d c=%0d exp 0 0", perf_grants, perf_conflicts);
        end
`endif
        cycle();
        tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL rst_empty got=%b exp=0", cdb_valid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] exp_rdy;
            reset  = ($urandom_range(0, 299) == 0);
            squash = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < N; i++) begin
                fu_valid[i]   = ($urandom_range(0, 9) < 6);
                fu_rd[i]      = 5'($urandom);
                fu_rob_tag[i] = TW'($urandom);
                fu_value[i]   = $urandom;
            end
            #1;
            exp_rdy = m_ready(squash);
            tests++; if (fu_ready !== exp_rdy) begin fails++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, fu_ready, exp_rdy); end
            cycle();
            tests++;
            if (cdb_valid !== e_valid || cdb_rd !== e_rd || cdb_rob_tag !== e_tag || cdb_value !== e_val || cdb_fu_id !== 2'(e_id)) begin
                fails++; $display("FAIL rnd_cdb c=%0d got v=%b rd=%0d tag=%0d val=%h id=%0d exp v=%b rd=%0d tag=%0d val=%h id=%0d",
                                  c, cdb_valid, cdb_rd, cdb_rob_tag, cdb_value, cdb_fu_id, e_valid, e_rd, e_tag, e_val, e_id);
            end
`ifdef CDB_PERF_CNT_EN
            tests++;
            if (perf_grants !== 32'(m_grants) || perf_conflicts !== 32'(m_conf)) begin
                fails++; $display("FAIL rnd_perf c=%0d got g=%0d c=%0d exp g=%0d c=%0d", c, perf_grants, perf_conflicts, m_grants, m_conf);
            end
`endif
        end
        reset = 1'b0; squash = 1'b0; fu_valid = '0;
    endtask

    initial begin
        reset = 1'b1; squash = 1'b0; fu_valid = '0;
        fu_rd = '0; fu_rob_tag = '0; fu_value = '0;
        test_reset();
        test_single_latency();
        test_all_requesting();
        test_back_to_back();
        test_squash();
        test_reset_dominates();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
